// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: requester (IF/MEM) and RAM-pin bundle for the shared byte-wide memory port.
// master = requesters plus RAM, slave = the controller.
interface mem_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req, if_flush, if_done;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_data;
   logic              mem_req, mem_we, mem_done;
   logic [1:0]        mem_len;
   logic [ADDR_W-1:0] mem_addr, ram_a;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic [7:0]        ram_dout, ram_din;
   logic              ram_wr;
   modport master (
      output if_req, if_addr, if_flush, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
      input  if_data, if_done, mem_rdata, mem_done, ram_a, ram_dout, ram_wr
   );
   modport slave (
      input  if_req, if_addr, if_flush, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
      output if_data, if_done, mem_rdata, mem_done, ram_a, ram_dout, ram_wr
   );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates IF and MEM onto one byte-wide RAM port, splitting 1/2/4-byte
// requests into little-endian byte beats and returning assembled words with done pulses.
module mem_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic     clk,
   input logic     rst,
   input logic     rdy,
   mem_ctrl_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3;
   localparam logic [1:0] O_NONE = 2'd0, O_IF = 2'd1, O_MEM = 2'd2;

   logic [1:0]        state, owner;
   logic [2:0]        cnt, n, len_n;
   logic [ADDR_W-1:0] base;
   logic [DATA_W-1:0] wdata, rbuf, rnext, if_q, mem_q;
   logic              flush;

   // cnt tracks the beat whose address is on the bus; RAM data lags by one beat
   always_comb begin
      len_n = bus.mem_len == 2'd0 ? 3'd1 : bus.mem_len == 2'd1 ? 3'd2 : 3'd4;
      rnext = rbuf | (DATA_W'(bus.ram_din) << {cnt - 3'd1, 3'b000});
      flush = state == READ && owner == O_IF && bus.if_flush;
   end

   assign bus.ram_a     = (state == READ || state == WRITE) ? base + ADDR_W'(cnt) : '0;
   assign bus.ram_dout  = state == WRITE ? 8'(wdata >> {cnt, 3'b000}) : 8'd0;
   assign bus.ram_wr    = state == WRITE && rdy;
   assign bus.if_done   = state == DONE && owner == O_IF;
   assign bus.mem_done  = state == DONE && owner == O_MEM;
   assign bus.if_data   = if_q;
   assign bus.mem_rdata = mem_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         owner <= O_NONE;
         cnt   <= '0;
         n     <= '0;
         base  <= '0;
         wdata <= '0;
         rbuf  <= '0;
         if_q  <= '0;
         mem_q <= '0;
      end else if (rdy) begin
         case (state)
            IDLE: begin
               if (bus.mem_req) begin
                  state <= bus.mem_we ? WRITE : READ;
                  owner <= O_MEM;
                  base  <= bus.mem_addr;
                  n     <= len_n;
                  wdata <= bus.mem_wdata;
                  cnt   <= '0;
                  rbuf  <= '0;
               end else if (bus.if_req) begin
                  state <= READ;
                  owner <= O_IF;
                  base  <= bus.if_addr;
                  n     <= 3'd4;
                  cnt   <= '0;
                  rbuf  <= '0;
               end
            end
            READ: begin
               if (flush) begin
                  state <= IDLE;
                  owner <= O_NONE;
               end else if (cnt == n) begin
                  state <= DONE;
                  if (owner == O_IF) if_q <= rnext;
                  else mem_q <= rnext;
               end else begin
                  cnt <= cnt + 3'd1;
                  if (cnt != 3'd0) rbuf <= rnext;
               end
            end
            WRITE: begin
               if (cnt == n - 3'd1) state <= DONE;
               else cnt <= cnt + 3'd1;
            end
            DONE: begin
               state <= IDLE;
               owner <= O_NONE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scenarios plus randomized transfers against a byte-array
// reference memory and latency rules derived from the beat counts.
module tb_mem_ctrl;
   logic clk = 0, rst = 1, rdy = 1;
   mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) b();
   mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(b));

   always #5 clk = ~clk;

   logic [7:0]  ram     [bit [31:0]];
   logic [7:0]  ref_mem [bit [31:0]];
   logic [39:0] beats   [$];
   int n_cmp = 0, n_err = 0;

   // RAM with one-cycle read latency, frozen by rdy like the controller
   always @(posedge clk) begin
      if (rdy) begin
         b.ram_din <= ram.exists(b.ram_a) ? ram[b.ram_a] : 8'h00;
         if (b.ram_wr) begin
            ram[b.ram_a] = b.ram_dout;
            beats.push_back({b.ram_a, b.ram_dout});
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [7:0] rb(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [31:0] a, input logic [7:0] d);
      ram[a] = d;
      ref_mem[a] = d;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic xfer(input string tag, input bit is_if, input bit we, input logic [1:0] len,
                       input logic [31:0] addr, input logic [31:0] wd, input int st_at,
                       input int st_len, output logic [31:0] rd);
      int n, edges, lat;
      bit got, wr;
      logic [31:0] exp;
      wr = we && !is_if;
      n = is_if ? 4 : (len == 2'd0 ? 1 : len == 2'd1 ? 2 : 4);
      exp = '0;
      for (int k = 0; k < n; k++) exp |= 32'(rb(addr + 32'(k))) << (8 * k);
      beats.delete();
      if (is_if) begin
         b.if_req = 1; b.if_addr = addr;
      end else begin
         b.mem_req = 1; b.mem_we = we; b.mem_len = len; b.mem_addr = addr; b.mem_wdata = wd;
      end
      edges = 0;
      got = 0;
      while (!got && edges < 40) begin
         tick();
         edges++;
         if (st_len > 0 && edges == st_at) rdy = 0;
         if (st_len > 0 && edges == st_at + st_len) rdy = 1;
         got = is_if ? b.if_done : b.mem_done;
      end
      rdy = 1;
      lat = (wr ? n + 1 : n + 2) + st_len;
      check({tag, " latency"}, 64'(edges), 64'(lat));
      rd = is_if ? b.if_data : b.mem_rdata;
      if (!wr) check({tag, " rdata"}, rd, exp);
      b.if_req = 0;
      b.mem_req = 0;
      tick();
      check({tag, " pulse"}, is_if ? b.if_done : b.mem_done, 0);
      if (wr) begin
         check({tag, " beats"}, 64'(beats.size()), 64'(n));
         foreach (beats[i]) check({tag, " beat"}, beats[i], {addr + 32'(i), 8'(wd >> (8 * i))});
         for (int k = 0; k < n; k++) ref_mem[addr + 32'(k)] = 8'(wd >> (8 * k));
      end else begin
         check({tag, " no writes"}, 64'(beats.size()), 0);
         check({tag, " hold"}, is_if ? b.if_data : b.mem_rdata, exp);
      end
   endtask

   initial begin
      logic [31:0] rd;
      int edges;
      bit got;
      b.if_req = 0; b.if_flush = 0; b.if_addr = 0;
      b.mem_req = 0; b.mem_we = 0; b.mem_len = 0; b.mem_addr = 0; b.mem_wdata = 0;
      #1 rst = 0;
      #1;
      check("reset ctl", {b.if_done, b.mem_done, b.ram_wr, b.ram_dout, b.ram_a}, 0);
      check("reset data", {b.if_data, b.mem_rdata}, 0);
      tick(); tick();
      rst = 1;
      tick();

      preload(32'h100, 8'h13); preload(32'h101, 8'h00); preload(32'h102, 8'h00); preload(32'h103, 8'h00);
      xfer("t1 if", 1, 0, 2'd0, 32'h100, 0, 0, 0, rd);
      check("t1 word", rd, 32'h13);

      xfer("t2 sw", 0, 1, 2'd2, 32'h20, 32'hDEADBEEF, 0, 0, rd);
      xfer("t2 lbu", 0, 0, 2'd0, 32'h23, 0, 0, 0, rd);
      check("t2 lbu val", rd, 32'hDE);

      preload(32'h40, 8'h34); preload(32'h41, 8'h12);
      b.if_req = 1; b.if_addr = 32'h100;
      b.mem_req = 1; b.mem_we = 0; b.mem_len = 2'd1; b.mem_addr = 32'h40;
      edges = 0;
      while (!b.mem_done && !b.if_done && edges < 20) begin tick(); edges++; end
      check("t3 mem first", {b.mem_done, b.if_done}, 2'b10);
      check("t3 mem lat", 64'(edges), 4);
      check("t3 lh", b.mem_rdata, 32'h1234);
      b.mem_req = 0;
      edges = 0;
      while (!b.if_done && edges < 20) begin tick(); edges++; end
      check("t3 if lat", 64'(edges), 7);
      check("t3 if data", b.if_data, 32'h13);
      b.if_req = 0;
      tick();

      b.if_req = 1; b.if_addr = 32'h300;
      repeat (3) tick();
      check("t4 beat addr", b.ram_a, 32'h302);
      b.if_flush = 1; b.if_req = 0;
      tick();
      b.if_flush = 0;
      got = 0;
      repeat (8) begin got |= b.if_done; tick(); end
      check("t4 no done", got, 0);
      preload(32'h200, 8'h93); preload(32'h201, 8'h02); preload(32'h202, 8'h10); preload(32'h203, 8'h00);
      xfer("t4 if", 1, 0, 2'd0, 32'h200, 0, 0, 0, rd);
      check("t4 word", rd, 32'h00100293);

      preload(32'h180, 8'hA1); preload(32'h181, 8'hB2); preload(32'h182, 8'hC3); preload(32'h183, 8'hD4);
      xfer("t5 stall", 1, 0, 2'd0, 32'h180, 0, 2, 3, rd);
      check("t5 word", rd, 32'hD4C3B2A1);

      beats.delete();
      b.mem_req = 1; b.mem_we = 1; b.mem_len = 2'd2; b.mem_addr = 32'h80; b.mem_wdata = 32'h11223344;
      repeat (3) tick();
      check("t6 wr active", b.ram_wr, 1);
      #2 rst = 0;
      #1;
      check("t6 async ctl", {b.ram_wr, b.mem_done, b.if_done, b.ram_dout, b.ram_a}, 0);
      check("t6 async data", {b.if_data, b.mem_rdata}, 0);
      b.mem_req = 0;
      tick();
      rst = 1;
      check("t6 beats", 64'(beats.size()), 2);
      ref_mem[32'h80] = 8'h44;
      ref_mem[32'h81] = 8'h33;
      got = 0;
      repeat (6) begin got |= b.mem_done; tick(); end
      check("t6 no done", got, 0);
      xfer("t6 lw", 0, 0, 2'd2, 32'h80, 0, 0, 0, rd);
      check("t6 partial", rd, 32'h00003344);

      xfer("t6 wrap", 0, 1, 2'd2, 32'hFFFFFFFE, 32'hCAFEF00D, 0, 0, rd);
      check("t6 wrap addr", 64'(beats[2][39:8]), 0);
      xfer("t6 wrap rd", 0, 0, 2'd3, 32'hFFFFFFFE, 0, 0, 0, rd);

      repeat (80) begin
         bit is_if, we;
         logic [1:0] len;
         logic [31:0] a, wd;
         int n, sa, sl;
         is_if = $urandom_range(0, 3) == 0;
         we = !is_if && ($urandom_range(0, 1) == 1);
         len = 2'($urandom_range(0, 3));
         a = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 63)) : 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
         wd = $urandom;
         n = is_if ? 4 : (len == 2'd0 ? 1 : len == 2'd1 ? 2 : 4);
         sl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
         sa = int'($urandom_range(1, we ? n : n + 1));
         xfer("rnd", is_if, we, len, a, wd, sa, sl, rd);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
